// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
package regfile_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned ZERO_REG       = 0;

  // Widest busy vector the popcount helper accepts (ADDR_WIDTH up to 8).
  localparam int unsigned MAX_REGS = 256;

  function automatic logic [8:0] popcount(input logic [MAX_REGS-1:0] v);
    logic [8:0] n;
    n = '0;
    for (int unsigned i = 0; i < MAX_REGS; i++) begin
      n = n + 9'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One combinational read port: zero-index masking, write bypass and busy masking.
module regfile_rd_port
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_WR     = 1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]        i_rd_addr,
  input  logic [DATA_WIDTH-1:0]        i_stored_data,
  input  logic                         i_stored_busy,
  input  logic [NUM_WR-1:0]            i_wr_en,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [NUM_WR*DATA_WIDTH-1:0] i_wr_data,
  output logic [DATA_WIDTH-1:0]        o_rd_data,
  output logic                         o_rd_busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  always_comb begin
    o_rd_data = i_stored_data;
    o_rd_busy = i_stored_busy;
    // Ascending scan so the highest-numbered matching write port is the one forwarded.
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (BYPASS && i_wr_en[k] && (i_wr_addr[k*ADDR_WIDTH +: ADDR_WIDTH] == i_rd_addr)) begin
        o_rd_data = i_wr_data[k*DATA_WIDTH +: DATA_WIDTH];
        o_rd_busy = 1'b0;
      end
    end
    if (i_rd_addr == ZERO_IDX) begin
      o_rd_data = '0;
      o_rd_busy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file (x0 hardwired to zero) with a busy-bit scoreboard for hazard stalls.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data_o,
  output logic [NUM_RD-1:0]            rd_busy_o,
  input  logic [NUM_WR-1:0]            wr_en_i,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data_i,
  input  logic                         issue_en_i,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_i,
  output logic                         issue_ok_o,
  output logic [ADDR_WIDTH:0]          pending_cnt_o,
  input  logic [ADDR_WIDTH-1:0]        dbg_addr_i,
  output logic [DATA_WIDTH-1:0]        dbg_data_o
);

  localparam int unsigned           DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(ZERO_REG);

  logic [DATA_WIDTH-1:0] r_regs [DEPTH];
  logic [DEPTH-1:0]      r_busy;
  logic [DEPTH-1:0]      w_busy_nxt;
  logic [MAX_REGS-1:0]   w_busy_ext;
  logic [ADDR_WIDTH:0]   r_pending;
  logic [ADDR_WIDTH:0]   w_pending_nxt;

  // Highest write port is applied last, so it wins on an index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_regs <= '{default: '0};
    end else begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (wr_en_i[k] && (wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH] != ZERO_IDX)) begin
          r_regs[wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] <= wr_data_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  assign issue_ok_o = issue_en_i && ((issue_rd_i == ZERO_IDX) || !r_busy[issue_rd_i]);

  // Set is applied after the clears so an accepted issue overrides a same-cycle write.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_en_i[k]) begin
        w_busy_nxt[wr_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH]] = 1'b0;
      end
    end
    if (issue_ok_o && (issue_rd_i != ZERO_IDX)) begin
      w_busy_nxt[issue_rd_i] = 1'b1;
    end
  end

  always_comb begin
    w_busy_ext              = '0;
    w_busy_ext[DEPTH-1:0]   = w_busy_nxt;
    w_pending_nxt           = (ADDR_WIDTH+1)'(popcount(w_busy_ext));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy    <= '0;
      r_pending <= '0;
    end else begin
      r_busy    <= w_busy_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign pending_cnt_o = r_pending;
  assign dbg_data_o    = r_regs[dbg_addr_i];

  for (genvar j = 0; j < NUM_RD; j++) begin : g_rd
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    assign w_rd_addr = rd_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_rd_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WR     (NUM_WR),
      .BYPASS     (BYPASS)
    ) u_rd_port (
      .i_rd_addr     (w_rd_addr),
      .i_stored_data (r_regs[w_rd_addr]),
      .i_stored_busy (r_busy[w_rd_addr]),
      .i_wr_en       (wr_en_i),
      .i_wr_addr     (wr_addr_i),
      .i_wr_data     (wr_data_i),
      .o_rd_data     (rd_data_o[j*DATA_WIDTH +: DATA_WIDTH]),
      .o_rd_busy     (rd_busy_o[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: bypassing and non-bypassing instances share stimulus, checked against an array model.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [1:0]  wr_en;
  logic [9:0]  wr_addr;
  logic [63:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic [4:0]  dbg_addr;

  logic [63:0] b_rdata,  n_rdata;
  logic [1:0]  b_rbusy,  n_rbusy;
  logic        b_ok,     n_ok;
  logic [5:0]  b_pend,   n_pend;
  logic [31:0] b_dbg,    n_dbg;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] m_regs [32];
  bit          m_busy [32];

  regfile_mp #(
    .ADDR_WIDTH (5), .DATA_WIDTH (32), .NUM_RD (2), .NUM_WR (2), .BYPASS (1'b1)
  ) u_dut_byp (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (rd_addr), .rd_data_o (b_rdata), .rd_busy_o (b_rbusy),
    .wr_en_i (wr_en), .wr_addr_i (wr_addr), .wr_data_i (wr_data),
    .issue_en_i (issue_en), .issue_rd_i (issue_rd), .issue_ok_o (b_ok),
    .pending_cnt_o (b_pend), .dbg_addr_i (dbg_addr), .dbg_data_o (b_dbg)
  );

  regfile_mp #(
    .ADDR_WIDTH (5), .DATA_WIDTH (32), .NUM_RD (2), .NUM_WR (2), .BYPASS (1'b0)
  ) u_dut_nobyp (
    .clk (clk), .rst_n (rst_n),
    .rd_addr_i (rd_addr), .rd_data_o (n_rdata), .rd_busy_o (n_rbusy),
    .wr_en_i (wr_en), .wr_addr_i (wr_addr), .wr_data_i (wr_data),
    .issue_en_i (issue_en), .issue_rd_i (issue_rd), .issue_ok_o (n_ok),
    .pending_cnt_o (n_pend), .dbg_addr_i (dbg_addr), .dbg_data_o (n_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    for (int r = 0; r < 32; r++) begin
      m_regs[r] = '0;
      m_busy[r] = 1'b0;
    end
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int r = 0; r < 32; r++) n += int'(m_busy[r]);
    return n;
  endfunction

  function automatic bit model_issue_ok();
    return issue_en && (issue_rd == 5'd0 || !m_busy[issue_rd]);
  endfunction

  function automatic void model_read(input bit byp, input int j,
                                     output logic [31:0] d, output logic b);
    int a;
    a = int'(rd_addr[j*5 +: 5]);
    d = m_regs[a];
    b = m_busy[a];
    if (byp) begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k] && int'(wr_addr[k*5 +: 5]) == a) begin
          d = wr_data[k*32 +: 32];
          b = 1'b0;
        end
      end
    end
    if (a == 0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  // Per-register rule: accepted issue sets, otherwise any write clears, otherwise hold.
  function automatic void model_commit();
    bit ok;
    bit nb [32];
    bit hit;
    ok = model_issue_ok();
    for (int r = 0; r < 32; r++) begin
      hit = 1'b0;
      for (int k = 0; k < 2; k++)
        if (wr_en[k] && int'(wr_addr[k*5 +: 5]) == r) hit = 1'b1;
      if (r != 0 && ok && int'(issue_rd) == r) nb[r] = 1'b1;
      else if (hit)                             nb[r] = 1'b0;
      else                                      nb[r] = m_busy[r];
    end
    for (int k = 0; k < 2; k++)
      if (wr_en[k] && wr_addr[k*5 +: 5] != 5'd0) m_regs[wr_addr[k*5 +: 5]] = wr_data[k*32 +: 32];
    for (int r = 0; r < 32; r++) m_busy[r] = nb[r];
  endfunction

  task automatic check_all();
    logic [31:0] ed;
    logic        eb;
    for (int j = 0; j < 2; j++) begin
      model_read(1'b1, j, ed, eb);
      check($sformatf("byp_rd%0d_data", j), b_rdata[j*32 +: 32], ed);
      check($sformatf("byp_rd%0d_busy", j), 32'(b_rbusy[j]), 32'(eb));
      model_read(1'b0, j, ed, eb);
      check($sformatf("nob_rd%0d_data", j), n_rdata[j*32 +: 32], ed);
      check($sformatf("nob_rd%0d_busy", j), 32'(n_rbusy[j]), 32'(eb));
    end
    check("byp_issue_ok", 32'(b_ok), 32'(model_issue_ok()));
    check("nob_issue_ok", 32'(n_ok), 32'(model_issue_ok()));
    check("byp_pending", 32'(b_pend), 32'(model_pending()));
    check("nob_pending", 32'(n_pend), 32'(model_pending()));
    check("byp_dbg", b_dbg, m_regs[dbg_addr]);
    check("nob_dbg", n_dbg, m_regs[dbg_addr]);
  endtask

  // Entered 1 time unit after a rising edge; leaves 1 time unit after the next one.
  task automatic cycle();
    #4;
    check_all();
    if (rst_n) model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    issue_en = 1'b0;
    issue_rd = '0;
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [31:0] d);
    wr_en[k]          = 1'b1;
    wr_addr[k*5 +: 5] = a;
    wr_data[k*32 +: 32] = d;
  endtask

  task automatic issue(input logic [4:0] a);
    issue_en = 1'b1;
    issue_rd = a;
  endtask

  initial begin
    rst_n    = 1'b0;
    idle();
    model_reset();
    rd_addr  = {5'd0, 5'd5};
    dbg_addr = 5'd5;
    issue(5'd3);
    #2;
    check("rst_rd_data", b_rdata[31:0], 32'h0);
    check("rst_rd_busy", 32'(b_rbusy), 32'h0);
    check("rst_pending", 32'(b_pend), 32'h0);
    check("rst_issue_ok", 32'(b_ok), 32'h1);
    check_all();
    idle();
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Write collision on x7, then a dropped write to x0.
    wr(0, 5'd7, 32'h1111);
    wr(1, 5'd7, 32'h2222);
    cycle();
    idle();
    rd_addr  = {5'd0, 5'd7};
    dbg_addr = 5'd7;
    #1;
    check("collision_x7", b_rdata[31:0], 32'h2222);
    check("collision_dbg", b_dbg, 32'h2222);
    wr(0, 5'd0, 32'hFFFF);
    cycle();
    idle();
    #1;
    check("x0_stays_zero", b_rdata[63:32], 32'h0);

    // Bypass over a busy register.
    wr(0, 5'd3, 32'h1234);
    issue(5'd3);
    cycle();
    idle();
    wr(1, 5'd3, 32'hABCD);
    rd_addr = {5'd0, 5'd3};
    #1;
    check("bypass_data", b_rdata[31:0], 32'hABCD);
    check("bypass_busy", 32'(b_rbusy[0]), 32'h0);
    check("nobypass_data", n_rdata[31:0], 32'h1234);
    check("nobypass_busy", 32'(n_rbusy[0]), 32'h1);
    cycle();
    idle();

    // Scoreboard set, refused re-issue, clear on write.
    issue(5'd4);
    cycle();
    idle();
    rd_addr = {5'd0, 5'd4};
    issue(5'd4);
    #1;
    check("sb_busy_x4", 32'(b_rbusy[0]), 32'h1);
    check("sb_pending1", 32'(b_pend), 32'h1);
    check("sb_reissue_refused", 32'(b_ok), 32'h0);
    cycle();
    idle();
    wr(0, 5'd4, 32'h44);
    cycle();
    idle();
    #1;
    check("sb_pending0", 32'(b_pend), 32'h0);

    // Clear x9 while setting x10; then issue and write x9 together.
    issue(5'd9);
    cycle();
    idle();
    wr(0, 5'd9, 32'h99);
    issue(5'd10);
    cycle();
    idle();
    rd_addr = {5'd10, 5'd9};
    #1;
    check("sim_pending", 32'(b_pend), 32'h1);
    check("sim_x9_busy", 32'(b_rbusy[0]), 32'h0);
    check("sim_x10_busy", 32'(b_rbusy[1]), 32'h1);
    wr(1, 5'd10, 32'hA0);
    cycle();
    idle();
    wr(0, 5'd9, 32'h55);
    issue(5'd9);
    cycle();
    idle();
    rd_addr = {5'd0, 5'd9};
    #1;
    check("iw_x9_data", n_rdata[31:0], 32'h55);
    check("iw_x9_busy", 32'(n_rbusy[0]), 32'h1);
    cycle();

    // Mid-operation asynchronous reset.
    issue(5'd1);
    cycle();
    issue(5'd5);
    wr(0, 5'd2, 32'h5);
    cycle();
    idle();
    issue(5'd6);
    wr(1, 5'd7, 32'h77);
    #2 rst_n = 1'b0;
    #1 idle();
    rd_addr  = {5'd5, 5'd2};
    dbg_addr = 5'd2;
    #1;
    check("mrst_pending", 32'(b_pend), 32'h0);
    check("mrst_x2_data", b_rdata[31:0], 32'h0);
    check("mrst_x5_busy", 32'(b_rbusy[1]), 32'h0);
    model_reset();
    check_all();
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(5'd9);
    cycle();
    idle();

    // Randomized traffic, biased to a small index range to provoke collisions.
    for (int i = 0; i < 600; i++) begin
      idle();
      for (int k = 0; k < 2; k++)
        if ($urandom_range(0, 2) == 0)
          wr(k, 5'($urandom_range(0, 11)), $urandom);
      if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 11)));
      rd_addr  = {5'($urandom_range(0, 11)), 5'($urandom_range(0, 11))};
      dbg_addr = 5'($urandom_range(0, 31));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
